// File: rtl/sprite_fetch.sv
// Sprite pixel-fetch stage: bounding-box test, ROM address generation with optional
// mirroring, and re-alignment of the registered ROM output into a palette index.
module sprite_fetch #(
   parameter int unsigned NUM_FRAMES = 16
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic [9:0]  spr_x,
   input  logic [9:0]  spr_y,
   input  logic [3:0]  spr_dir,
   input  logic        spr_en,
   input  logic [4:0]  rom_data,
   output logic [13:0] read_address,
   output logic [2:0]  pixel_idx,
   output logic        pixel_on
);

   localparam int unsigned POS_W  = 10;
   localparam int unsigned OFS_W  = POS_W + 1;
   localparam int unsigned SPR_SZ = 32;

   logic             fc_d;
   logic             fc_rise;
   logic [POS_W-1:0] sx;
   logic [POS_W-1:0] sy;
   logic [3:0]       dir;
   logic             en;
   logic             v1;
   logic             v2;

   logic [OFS_W-1:0] dx;
   logic [OFS_W-1:0] dy;
   logic             in_box;
   logic [3:0]       frame;
   logic             mirror;
   logic [4:0]       lx;
   logic [13:0]      addr_next;
   logic             unused_rom_bits;

   assign fc_rise         = frame_clk & ~fc_d;
   assign unused_rom_bits = ^rom_data[4:3];

   // Sprite state is only sampled on the frame strobe so a sprite never tears mid-frame
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         fc_d <= 1'b0;
         sx   <= '0;
         sy   <= '0;
         dir  <= '0;
         en   <= 1'b0;
      end else begin
         fc_d <= frame_clk;
         if (fc_rise) begin
            sx  <= spr_x;
            sy  <= spr_y;
            dir <= spr_dir;
            en  <= spr_en;
         end
      end
   end

   // Box test and frame/mirror selection; directions past 8 reuse frames 7..1 flipped
   always_comb begin
      dx     = {1'b0, DrawX} - {1'b0, sx};
      dy     = {1'b0, DrawY} - {1'b0, sy};
      in_box = en && (DrawX >= sx) && (DrawY >= sy) &&
               (dx < OFS_W'(SPR_SZ)) && (dy < OFS_W'(SPR_SZ));
      frame  = dir;
      mirror = 1'b0;
      if (NUM_FRAMES == 9 && dir > 4'd8) begin
         frame  = 4'(5'd16 - {1'b0, dir});
         mirror = 1'b1;
      end
      lx        = mirror ? (5'd31 - dx[4:0]) : dx[4:0];
      addr_next = {frame, dy[4:0], lx};
   end

   // Stage 1: address register (held when outside the box) and valid flag
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         read_address <= '0;
         v1           <= 1'b0;
      end else begin
         if (in_box) begin
            read_address <= addr_next;
         end
         v1 <= in_box;
      end
   end

   // Stages 2-3: valid follows the ROM's own register, then the pixel is formed
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         v2        <= 1'b0;
         pixel_idx <= '0;
         pixel_on  <= 1'b0;
      end else begin
         v2        <= v1;
         pixel_idx <= v2 ? rom_data[2:0] : 3'd0;
         pixel_on  <= v2 && (rom_data[2:0] != 3'd0);
      end
   end

endmodule

// File: doc/sprite_fetch.md
# sprite_fetch

Pixel-fetch stage directly upstream of the sprite ROMs (tank sheet and player-2 sheets a–e). Each cycle it takes the VGA scan position, tests it against one sprite's bounding box, and drives the ROM `read_address`. It applies horizontal mirroring for 9-frame sheets and re-aligns the registered ROM output into a 3-bit palette index plus an opaque flag for the color mapper. Sprite position, direction and enable are double-buffered on the frame strobe so a sprite never tears mid-frame.

## Interface
- `NUM_FRAMES`, default 16, legal values 16 or 9. 16 means one 32x32 frame per direction. 9 means frames 0–8 are stored and directions 9–15 are mirrored.
- `Clk` input, 1 bit: pixel clock, rising edge.
- `Reset` input, 1 bit: asynchronous, active-high.
- `frame_clk` input, 1 bit: vertical-sync strobe, same clock domain; its rising edge latches the sprite state.
- `DrawX` input, 10 bits: current scan column, 0–639.
- `DrawY` input, 10 bits: current scan row, 0–479.
- `spr_x` input, 10 bits: sprite top-left column, live value.
- `spr_y` input, 10 bits: sprite top-left row, live value.
- `spr_dir` input, 4 bits: direction 0–15, live value.
- `spr_en` input, 1 bit: sprite visible, live value.
- `rom_data` input, 5 bits: ROM `data_Out`. Only bits [2:0] are used.
- `read_address` output, 14 bits: ROM address, registered.
- `pixel_idx` output, 3 bits: palette index, registered.
- `pixel_on` output, 1 bit: sprite pixel is opaque at the current output position, registered.

## Operation
- **Edge detect:** `fc_d` holds `frame_clk` delayed one cycle; `fc_rise = frame_clk & ~fc_d`.
- **Shadow latch:** on `fc_rise`, shadow registers take `spr_x`, `spr_y`, `spr_dir`, `spr_en`. All drawing uses the shadow values only.
- **Stage 1 (registered):**
  - Offsets are computed at 11 bits: `dx = {0,DrawX} - {0,sx}` and `dy = {0,DrawY} - {0,sy}`.
  - `in_box = en & DrawX>=sx & DrawY>=sy & dx<32 & dy<32`.
  - Frame selection for `NUM_FRAMES`=16: `frame = dir`, `mirror = 0`.
  - Frame selection for `NUM_FRAMES`=9: if `dir<=8`, then `frame = dir`, `mirror = 0`; otherwise `frame = 16-dir`, `mirror = 1`.
  - `lx = mirror ? 31-dx[4:0] : dx[4:0]`.
  - `read_address <= frame*1024 + dy[4:0]*32 + lx`. The address is held at its previous value when `in_box=0`.
  - `v1 <= in_box`.
- **Stage 2:** the ROM registers `data_Out` from `read_address`. This block only delays the valid flag: `v2 <= v1`.
- **Stage 3 (registered):**
  - `pixel_idx <= v2 ? rom_data[2:0] : 0`.
  - `pixel_on <= v2 & (rom_data[2:0] != 0)`. Index 0 is transparent.
- **Boundary conditions:**
  - A box extending past column 639 or row 479 is clipped naturally; there is no wrap to column 0.
  - `spr_x` near 1023 produces no pixels.

## Timing
- **Latency:** 3 cycles from `DrawX`/`DrawY` to `pixel_idx`/`pixel_on`. `read_address` appears 1 cycle after its `DrawX`/`DrawY`.
- **Throughput:** one pixel per cycle, no stalls.
- **Shadow update timing:**
  - Shadow values change the cycle after `fc_rise` and affect the stage-1 computation from that cycle onward.
  - Pixels already in stages 2 and 3 complete with their old address.
  - A `spr_*` change that arrives together with `fc_rise` is captured.
  - A `spr_*` change without `fc_rise` has no effect.
- **Reset values** (immediate, asynchronous): `read_address=0`, `pixel_idx=0`, `pixel_on=0`; `v1`, `v2`, `fc_d`, shadow registers (including `en`) all 0.
- **Reset mid-line:** `pixel_on` drops in the same cycle. After release, the first valid output comes 3 cycles later, and only after a `fc_rise` has loaded `en=1`.
- **Held-high `frame_clk`:** exactly one latch per rising edge.

## Test plan
- **Basic fetch:** frame pulse with `spr_x=100`, `spr_y=50`, `dir=3`, `en=1`; scan to `DrawX=105`, `DrawY=52` -> `read_address=3*1024+2*32+5=3141` one cycle later. With `rom_data=5`, `pixel_idx=5` and `pixel_on=1` three cycles after the scan position.
- **Bounds and transparency:** at `DrawX=99` and `DrawX=132` (same row) -> `pixel_on=0`. At `DrawX=131` with `rom_data=0` -> `pixel_on=0`, `pixel_idx=0`.
- **Mirroring (`NUM_FRAMES=9`):** with `dir=12`, `dx=0`, `dy=0` -> `read_address=4*1024+31=4127`. With `dir=8` -> `read_address=8192`.
- **Frame-strobe latching:** change `spr_x` from 100 to 200 without a `frame_clk` edge -> `DrawX=105` still hits. After a `frame_clk` rising edge -> `DrawX=105` misses and `DrawX=205` hits.
- **Clipping:** `spr_x=620`, `spr_y=470` -> pixels only for `DrawX` 620–639 and `DrawY` 470–479; nothing at `DrawX=0`.
- **Reset mid-operation:** assert `Reset` while `pixel_on=1` -> `pixel_on=0` in the same cycle. After release with no frame pulse -> `pixel_on` stays 0 (`en` cleared).
